// File: rtl/emu_sched_pkg.sv
// emu_sched_pkg: shared state/opcode types and dt saturation limit for the emulation time-step scheduler
package emu_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STEP, ST_UNTIL} sched_state_t;
  typedef enum logic [1:0] {OP_PAUSE, OP_RUN, OP_STEP_N, OP_RUN_UNTIL} sched_op_t;
  function automatic logic [63:0] dt_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/dt_min_tree.sv
// dt_min_tree: masked signed-min of dt requests; negatives clamp to 0 and raise neg
module dt_min_tree import emu_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DT_WIDTH = 27
) (
  input  logic [N_REQ*DT_WIDTH-1:0] dt_req,
  input  logic [N_REQ-1:0]          req_en,
  output logic signed [DT_WIDTH-1:0] min_req,
  output logic                       neg
);
  localparam logic signed [DT_WIDTH-1:0] DMAX = DT_WIDTH'(dt_max(DT_WIDTH));
  always_comb begin
    logic signed [DT_WIDTH-1:0] v;
    min_req = DMAX;
    neg = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      v = dt_req[i*DT_WIDTH +: DT_WIDTH];
      neg = neg | (req_en[i] & v[DT_WIDTH-1]);
      v = v[DT_WIDTH-1] ? '0 : v;
      if (req_en[i] && v < min_req) min_req = v;
    end
  end
endmodule

// File: rtl/emu_time_sched.sv
// emu_time_sched: issues the common emulator dt each cycle, accumulates emulated time,
// and runs the host pause/run/step-N/run-until command FSM
module emu_time_sched import emu_sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int DT_WIDTH = 27,
  parameter int TIME_WIDTH = 64
) (
  input  logic                         __emu_clk,
  input  logic                         __emu_rst_n,
  input  logic [N_REQ*DT_WIDTH-1:0]    dt_req,
  input  logic [N_REQ-1:0]             req_en,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [TIME_WIDTH-1:0]        cmd_arg,
  output logic signed [DT_WIDTH-1:0]   dt,
  output logic [TIME_WIDTH-1:0]        emu_time,
  output logic                         stalled,
  output logic                         done,
  output logic                         err_neg
);
  localparam logic [DT_WIDTH-1:0] DMAX = DT_WIDTH'(dt_max(DT_WIDTH));
  sched_state_t state;
  logic [TIME_WIDTH-1:0] step_cnt, target, diff, time_nx;
  logic [DT_WIDTH-1:0] clamp;
  logic signed [DT_WIDTH-1:0] min_req;
  logic neg;
  dt_min_tree #(.N_REQ(N_REQ), .DT_WIDTH(DT_WIDTH)) u_min (
    .dt_req(dt_req), .req_en(req_en), .min_req(min_req), .neg(neg)
  );
  // remaining distance to target, saturated so it fits a dt word
  always_comb begin
    diff = target - emu_time;
    clamp = diff > TIME_WIDTH'(DMAX) ? DMAX : diff[DT_WIDTH-1:0];
    dt = state == ST_IDLE ? '0 :
         (state == ST_UNTIL && $signed(clamp) < min_req) ? $signed(clamp) : min_req;
    time_nx = emu_time + TIME_WIDTH'($unsigned(dt));
  end
  assign stalled = state == ST_IDLE;
  assign cmd_ready = 1'b1;
  always_ff @(posedge __emu_clk or negedge __emu_rst_n) begin
    if (!__emu_rst_n) begin
      state <= ST_IDLE;
      emu_time <= '0;
      step_cnt <= '0;
      target <= '0;
      done <= 1'b0;
      err_neg <= 1'b0;
    end else begin
      emu_time <= time_nx;
      err_neg <= err_neg | neg;
      done <= 1'b0;
      if (cmd_valid) begin
        case (sched_op_t'(cmd_op))
          OP_PAUSE: state <= ST_IDLE;
          OP_RUN: state <= ST_RUN;
          OP_STEP_N: begin
            step_cnt <= cmd_arg;
            state <= cmd_arg == '0 ? ST_IDLE : ST_STEP;
            done <= cmd_arg == '0;
          end
          OP_RUN_UNTIL: begin
            target <= cmd_arg;
            state <= cmd_arg <= emu_time ? ST_IDLE : ST_UNTIL;
            done <= cmd_arg <= emu_time;
          end
        endcase
      end else if (state == ST_STEP) begin
        step_cnt <= step_cnt - 1'b1;
        if (step_cnt == TIME_WIDTH'(1)) begin
          state <= ST_IDLE;
          done <= 1'b1;
        end
      end else if (state == ST_UNTIL && time_nx == target) begin
        state <= ST_IDLE;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_emu_time_sched.sv
// tb_emu_time_sched: directed self-checking bench for the emulation time-step scheduler
module tb_emu_time_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4*27-1:0] dt_req;
  logic [3:0] req_en;
  logic cmd_valid, cmd_ready, done, stalled, err_neg;
  logic [1:0] cmd_op;
  logic [63:0] cmd_arg, emu_time;
  logic signed [26:0] dt;
  int errors = 0, checks = 0;

  emu_time_sched dut (
    .__emu_clk(clk), .__emu_rst_n(rst_n), .dt_req(dt_req), .req_en(req_en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .dt(dt), .emu_time(emu_time), .stalled(stalled), .done(done), .err_neg(err_neg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [63:0] arg);
    cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
    tick();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    dt_req = {27'sd90, 27'sd70, 27'sd40, 27'sd100};
    req_en = 4'b1111; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (dt !== 27'sd0) begin errors++; $display("FAIL reset_dt got=%0d exp=0", dt); end
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL reset_stalled got=%b exp=1", stalled); end
    checks++; if (done !== 1'b0 || err_neg !== 1'b0) begin errors++; $display("FAIL reset_flags done=%b err=%b exp=0", done, err_neg); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (emu_time !== 64'd0 || dt !== 27'sd0) begin errors++; $display("FAIL idle_hold time=%0d dt=%0d exp=0", emu_time, dt); end
  endtask

  task automatic test_run();
    req_en = 4'b1101;
    issue(2'd1, 64'd0);
    checks++; if (dt !== 27'sd70 || stalled !== 1'b0) begin errors++; $display("FAIL run_dt got=%0d stalled=%b exp=70/0", dt, stalled); end
    repeat (10) tick();
    checks++; if (emu_time !== 64'd700) begin errors++; $display("FAIL run_time got=%0d exp=700", emu_time); end
    issue(2'd0, 64'd0);
    checks++; if (dt !== 27'sd0 || stalled !== 1'b1 || emu_time !== 64'd770) begin errors++; $display("FAIL pause dt=%0d stalled=%b time=%0d exp=0/1/770", dt, stalled, emu_time); end
  endtask

  task automatic test_step();
    int dones = 0, steps = 0;
    req_en = 4'b1111;
    issue(2'd2, 64'd3);
    for (int i = 0; i < 6; i++) begin
      if (!stalled) begin
        steps++;
        checks++; if (dt !== 27'sd40) begin errors++; $display("FAIL step_dt cyc=%0d got=%0d exp=40", i, dt); end
      end
      if (done) dones++;
      tick();
    end
    checks++; if (steps != 3 || dones != 1) begin errors++; $display("FAIL step_count steps=%0d dones=%0d exp=3/1", steps, dones); end
    checks++; if (emu_time !== 64'd890 || stalled !== 1'b1) begin errors++; $display("FAIL step_time got=%0d stalled=%b exp=890/1", emu_time, stalled); end
    issue(2'd2, 64'd0);
    checks++; if (done !== 1'b1 || emu_time !== 64'd890 || stalled !== 1'b1) begin errors++; $display("FAIL step0 done=%b time=%0d exp=1/890", done, emu_time); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL step0_pulse got=%b exp=0", done); end
    dt_req = {27'sd90, 27'sd70, 27'sd10, 27'sd100};
    issue(2'd2, 64'd1);
    checks++; if (dt !== 27'sd10 || done !== 1'b0) begin errors++; $display("FAIL step1_dt got=%0d done=%b exp=10/0", dt, done); end
    tick();
    checks++; if (done !== 1'b1 || emu_time !== 64'd900) begin errors++; $display("FAIL step1_done done=%b time=%0d exp=1/900", done, emu_time); end
    dt_req = {27'sd90, 27'sd70, 27'sd40, 27'sd100};
  endtask

  task automatic test_until();
    logic signed [26:0] exp_dt [3] = '{27'sd40, 27'sd40, 27'sd20};
    issue(2'd3, 64'd1000);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dt !== exp_dt[i] || done !== 1'b0) begin errors++; $display("FAIL until_dt cyc=%0d got=%0d done=%b exp=%0d", i, dt, done, exp_dt[i]); end
      tick();
    end
    checks++; if (done !== 1'b1 || emu_time !== 64'd1000 || stalled !== 1'b1) begin errors++; $display("FAIL until_done done=%b time=%0d stalled=%b exp=1/1000/1", done, emu_time, stalled); end
    tick();
    checks++; if (done !== 1'b0 || emu_time !== 64'd1000) begin errors++; $display("FAIL until_after done=%b time=%0d", done, emu_time); end
    issue(2'd3, 64'd500);
    checks++; if (done !== 1'b1 || emu_time !== 64'd1000 || stalled !== 1'b1) begin errors++; $display("FAIL until_past done=%b time=%0d exp=1/1000", done, emu_time); end
  endtask

  task automatic test_err_neg();
    dt_req = {27'sd30, 27'sd30, 27'sd30, -27'sd5};
    req_en = 4'b1111;
    issue(2'd1, 64'd0);
    checks++; if (dt !== 27'sd0 || err_neg !== 1'b1) begin errors++; $display("FAIL neg_dt dt=%0d err=%b exp=0/1", dt, err_neg); end
    dt_req = {27'sd30, 27'sd30, 27'sd30, 27'sd30};
    #1;
    checks++; if (dt !== 27'sd30) begin errors++; $display("FAIL pos_dt got=%0d exp=30", dt); end
    tick();
    checks++; if (err_neg !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_neg); end
    req_en = 4'b0000;
    #1;
    checks++; if (dt !== 27'sd67108863) begin errors++; $display("FAIL no_req got=%0d exp=67108863", dt); end
    req_en = 4'b1111;
    issue(2'd0, 64'd0);
  endtask

  task automatic test_preempt();
    int dones = 0;
    issue(2'd2, 64'd10);
    repeat (3) tick();
    issue(2'd1, 64'd0);
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      checks++; if (dt !== 27'sd30 || stalled !== 1'b0) begin errors++; $display("FAIL preempt_run cyc=%0d dt=%0d stalled=%b exp=30/0", i, dt, stalled); end
      tick();
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL preempt_done got=%0d exp=0", dones); end
  endtask

  task automatic test_reset_mid();
    issue(2'd3, 64'd1 << 40);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (dt !== 27'sd0 || stalled !== 1'b1 || emu_time !== 64'd0) begin errors++; $display("FAIL rst_mid dt=%0d stalled=%b time=%0d exp=0/1/0", dt, stalled, emu_time); end
    checks++; if (done !== 1'b0 || err_neg !== 1'b0) begin errors++; $display("FAIL rst_mid_flags done=%b err=%b exp=0/0", done, err_neg); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (stalled !== 1'b1 || emu_time !== 64'd0 || done !== 1'b0) begin errors++; $display("FAIL rst_release stalled=%b time=%0d done=%b", stalled, emu_time, done); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_until();
    test_err_neg();
    test_preempt();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
